// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU fetch/decode sequencer: instruction
// format, opcodes, FSM state encoding and the decoded-field bundle.
package cpu_pkg;

   localparam int unsigned PC_W_DEF    = 3;
   localparam int unsigned INSTR_W_DEF = 8;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_AND   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_STORE = 2'b11;

   localparam logic [INSTR_W_DEF-1:0] INSTR_HALT = 8'h00;

   // Field LSB positions within the 8-bit word; every field is 2 bits wide
   localparam int unsigned OPC_LSB = 6;
   localparam int unsigned RD_LSB  = 4;
   localparam int unsigned RS_LSB  = 2;
   localparam int unsigned MA_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef struct packed {
      logic [1:0] opcode;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [1:0] mem_addr;
      logic       is_halt;
   } instr_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of the instruction register into its fields, with the
// all-zero word flagged as HALT rather than ADD R0,R0.
import cpu_pkg::*;

module instr_field_decode (
   input  logic [INSTR_W_DEF-1:0] i_ir,
   output instr_fields_t          o_fields
);

   always_comb begin
      o_fields          = '0;
      o_fields.opcode   = i_ir[OPC_LSB +: 2];
      o_fields.rd       = i_ir[RD_LSB  +: 2];
      o_fields.rs       = i_ir[RS_LSB  +: 2];
      o_fields.mem_addr = i_ir[MA_LSB  +: 2];
      o_fields.is_halt  = (i_ir == INSTR_HALT);
   end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fixed 4-cycle fetch/decode/execute/writeback sequencer: drives the PC,
// latches the instruction register and issues registered one-cycle strobes.
import cpu_pkg::*;

module fetch_decode_ctrl #(
   parameter int unsigned PC_W    = PC_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [PC_W-1:0]    pc_addr,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               alu_op,
   output logic               alu_en,
   output logic [1:0]         rd,
   output logic [1:0]         rs,
   output logic [1:0]         mem_addr,
   output logic               mem_re,
   output logic               mem_we,
   output logic               reg_we,
   output logic               busy,
   output logic               halted
);

   state_t             r_state;
   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_ir;
   logic [1:0]         r_opcode;
   logic [1:0]         r_rd;
   logic [1:0]         r_rs;
   logic [1:0]         r_mem_addr;
   logic               r_alu_op;
   logic               r_alu_en;
   logic               r_mem_re;
   logic               r_mem_we;
   logic               r_reg_we;
   logic               r_busy;
   logic               r_halted;

   instr_fields_t      w_dec;

   instr_field_decode u_decode (
      .i_ir     (r_ir),
      .o_fields (w_dec)
   );

   // Strobes are registered on the transition into their state, so each is a
   // clean Moore output and the default-clear keeps them to one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_ir       <= '0;
         r_opcode   <= '0;
         r_rd       <= '0;
         r_rs       <= '0;
         r_mem_addr <= '0;
         r_alu_op   <= 1'b0;
         r_alu_en   <= 1'b0;
         r_mem_re   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_reg_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_alu_en <= 1'b0;
         r_mem_re <= 1'b0;
         r_mem_we <= 1'b0;
         r_reg_we <= 1'b0;
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  r_state  <= ST_FETCH;
                  r_pc     <= '0;
                  r_busy   <= 1'b1;
                  r_halted <= 1'b0;
               end
            end
            ST_FETCH: begin
               r_ir    <= instr_in;
               r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (w_dec.is_halt) begin
                  r_state  <= ST_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_state    <= ST_EXEC;
                  r_opcode   <= w_dec.opcode;
                  r_rd       <= w_dec.rd;
                  r_rs       <= w_dec.rs;
                  r_mem_addr <= w_dec.mem_addr;
                  r_alu_op   <= (w_dec.opcode == OP_AND);
                  case (w_dec.opcode)
                     OP_ADD, OP_AND: r_alu_en <= 1'b1;
                     OP_LOAD:        r_mem_re <= 1'b1;
                     default:        r_mem_we <= 1'b1;
                  endcase
               end
            end
            ST_EXEC: begin
               r_state  <= ST_WB;
               r_reg_we <= (r_opcode != OP_STORE);
            end
            ST_WB: begin
               r_state <= ST_FETCH;
               r_pc    <= r_pc + PC_W'(1);
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pc_addr  = r_pc;
   assign alu_op   = r_alu_op;
   assign alu_en   = r_alu_en;
   assign rd       = r_rd;
   assign rs       = r_rs;
   assign mem_addr = r_mem_addr;
   assign mem_re   = r_mem_re;
   assign mem_we   = r_mem_we;
   assign reg_we   = r_reg_we;
   assign busy     = r_busy;
   assign halted   = r_halted;

endmodule
